// File: rtl/timer_pkg.sv
// Shared types, BCD limits and BCD step helpers
// for the timer run/set sequencer.
package timer_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    SET_H = 2'd1,
    SET_M = 2'd2,
    SET_S = 2'd3
  } state_t;

  localparam logic [3:0] H_MAX  = 4'h9;
  localparam logic [7:0] MS_MAX = 8'h59;

  localparam logic [7:0] DV_ALL = 8'h1F;
  localparam logic [7:0] DV_H   = 8'h10;
  localparam logic [7:0] DV_M   = 8'h0C;
  localparam logic [7:0] DV_S   = 8'h03;

  function automatic logic [7:0] bcd_inc(
    input logic [7:0] v,
    input logic [7:0] max
  );
    if (v == max) return 8'h00;
    if (v[3:0] == 4'h9) return {v[7:4] + 4'h1, 4'h0};
    return v + 8'h01;
  endfunction

  function automatic logic [7:0] bcd_dec(
    input logic [7:0] v,
    input logic [7:0] max
  );
    if (v == 8'h00) return max;
    if (v[3:0] == 4'h0) return {v[7:4] - 4'h1, 4'h9};
    return v - 8'h01;
  endfunction

  // Packed-BCD compare equals numeric compare once both digits are <= 9.
  function automatic logic bcd_ok(
    input logic [7:0] v,
    input logic [7:0] max
  );
    return (v[3:0] <= 4'h9) && (v[7:4] <= 4'h9) && (v <= max);
  endfunction

endpackage

// File: rtl/btn_cond.sv
// Button conditioner: 2-FF sync, stability filter,
// and single-cycle pulse on the filtered rising edge.
module btn_cond #(
  parameter int DEBOUNCE = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic pulse
);

  localparam int CW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;

  logic          s1, s2;
  logic          level, level_d;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1      <= 1'b0;
      s2      <= 1'b0;
      level   <= 1'b0;
      level_d <= 1'b0;
      cnt     <= '0;
    end else begin
      s1      <= btn;
      s2      <= s1;
      level_d <= level;
      if (s2 == level) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE - 1)) begin
        level <= s2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  assign pulse = level & ~level_d;

endmodule

// File: rtl/timer_set_ctrl.sv
// Run/set sequencer: freezes the timer, edits H:MM:SS
// in BCD with blinking field, loads the result back.
module timer_set_ctrl
  import timer_pkg::*;
#(
  parameter int DEBOUNCE  = 1_000_000,
  parameter int BLINK_DIV = 25_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic       btn_dec,
  input  logic [3:0] cur_h,
  input  logic [7:0] cur_m,
  input  logic [7:0] cur_s,
  output logic       tick_en,
  output logic       load,
  output logic [3:0] load_h,
  output logic [7:0] load_m,
  output logic [7:0] load_s,
  output logic [7:0] digit_valid,
  output logic [1:0] mode
);

  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic mode_p, inc_p, dec_p;

  btn_cond #(.DEBOUNCE(DEBOUNCE)) u_mode (
    .clk(clk), .rst(rst), .btn(btn_mode), .pulse(mode_p)
  );
  btn_cond #(.DEBOUNCE(DEBOUNCE)) u_inc (
    .clk(clk), .rst(rst), .btn(btn_inc), .pulse(inc_p)
  );
  btn_cond #(.DEBOUNCE(DEBOUNCE)) u_dec (
    .clk(clk), .rst(rst), .btn(btn_dec), .pulse(dec_p)
  );

  state_t        state, state_n;
  logic [3:0]    edit_h, edit_h_n;
  logic [7:0]    edit_m, edit_m_n;
  logic [7:0]    edit_s, edit_s_n;
  logic          load_n;
  logic          ud;
  logic [7:0]    h8;
  logic [BW-1:0] bcnt;
  logic          phase;
  logic [7:0]    mask;

  always_comb begin
    state_n  = state;
    edit_h_n = edit_h;
    edit_m_n = edit_m;
    edit_s_n = edit_s;
    load_n   = 1'b0;
    h8       = {4'h0, edit_h};
    ud       = (state != RUN) && !mode_p && (inc_p ^ dec_p);
    case (state)
      RUN: if (mode_p) begin
        state_n  = SET_H;
        edit_h_n = bcd_ok({4'h0, cur_h}, {4'h0, H_MAX}) ? cur_h : 4'h0;
        edit_m_n = bcd_ok(cur_m, MS_MAX) ? cur_m : 8'h00;
        edit_s_n = bcd_ok(cur_s, MS_MAX) ? cur_s : 8'h00;
      end
      SET_H: if (mode_p) state_n = SET_M;
        else if (ud) begin
          h8 = inc_p ? bcd_inc(h8, {4'h0, H_MAX})
                     : bcd_dec(h8, {4'h0, H_MAX});
          edit_h_n = h8[3:0];
        end
      SET_M: if (mode_p) state_n = SET_S;
        else if (ud) edit_m_n = inc_p ? bcd_inc(edit_m, MS_MAX)
                                      : bcd_dec(edit_m, MS_MAX);
      SET_S: if (mode_p) begin
          state_n = RUN;
          load_n  = 1'b1;
        end else if (ud) edit_s_n = inc_p ? bcd_inc(edit_s, MS_MAX)
                                          : bcd_dec(edit_s, MS_MAX);
      default: state_n = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= RUN;
      edit_h <= 4'h0;
      edit_m <= 8'h00;
      edit_s <= 8'h00;
      load   <= 1'b0;
    end else begin
      state  <= state_n;
      edit_h <= edit_h_n;
      edit_m <= edit_m_n;
      edit_s <= edit_s_n;
      load   <= load_n;
    end
  end

  // Blink restarts on every state change or accepted edit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bcnt  <= '0;
      phase <= 1'b1;
    end else if (state_n != state || ud || state == RUN) begin
      bcnt  <= '0;
      phase <= 1'b1;
    end else if (bcnt == BW'(BLINK_DIV - 1)) begin
      bcnt  <= '0;
      phase <= ~phase;
    end else begin
      bcnt <= bcnt + BW'(1);
    end
  end

  always_comb begin
    mask = 8'h00;
    case (state)
      SET_H:   mask = DV_H;
      SET_M:   mask = DV_M;
      SET_S:   mask = DV_S;
      default: mask = 8'h00;
    endcase
  end

  // Edit regs are untouched in RUN, so they also hold the last load.
  assign load_h      = edit_h;
  assign load_m      = edit_m;
  assign load_s      = edit_s;
  assign tick_en     = (state == RUN) && !load;
  assign digit_valid = phase ? DV_ALL : (DV_ALL & ~mask);
  assign mode        = state;

endmodule

// File: tb/tb_timer_set_ctrl.sv
// Directed bench for timer_set_ctrl with short
// debounce and blink periods.
module tb_timer_set_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_mode, btn_inc, btn_dec;
  logic [3:0] cur_h;
  logic [7:0] cur_m, cur_s;
  logic       tick_en, load;
  logic [3:0] load_h;
  logic [7:0] load_m, load_s;
  logic [7:0] digit_valid;
  logic [1:0] mode;

  int tests = 0;
  int fails = 0;
  logic load_seen;

  timer_set_ctrl #(.DEBOUNCE(4), .BLINK_DIV(8)) dut (
    .clk(clk), .rst(rst),
    .btn_mode(btn_mode), .btn_inc(btn_inc), .btn_dec(btn_dec),
    .cur_h(cur_h), .cur_m(cur_m), .cur_s(cur_s),
    .tick_en(tick_en), .load(load),
    .load_h(load_h), .load_m(load_m), .load_s(load_s),
    .digit_valid(digit_valid), .mode(mode)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Press acts 7 edges after the raw level rises.
  task automatic press(input logic m, input logic i, input logic d);
    btn_mode = m;
    btn_inc  = i;
    btn_dec  = d;
    tick(10);
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    btn_dec  = 1'b0;
    tick(10);
  endtask

  initial begin
    rst = 1'b0;
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    btn_dec  = 1'b0;
    cur_h = 4'h9;
    cur_m = 8'h58;
    cur_s = 8'h30;
    tick(3);
    rst = 1'b1;
    tick(2);

    chk("rst_tick_en", tick_en, 1);
    chk("rst_load", load, 0);
    chk("rst_mode", mode, 0);
    chk("rst_dv", digit_valid, 8'h1F);
    chk("rst_load_h", load_h, 0);

    btn_mode = 1'b1;
    tick(6);
    chk("pre_mode", mode, 0);
    tick(1);
    chk("seth_mode", mode, 1);
    chk("seth_tick_en", tick_en, 0);
    chk("cap_h", load_h, 4'h9);
    chk("cap_m", load_m, 8'h58);
    chk("cap_s", load_s, 8'h30);
    chk("blink_on0", digit_valid, 8'h1F);
    tick(7);
    chk("blink_on7", digit_valid, 8'h1F);
    tick(1);
    chk("blink_off", digit_valid, 8'h0F);
    tick(8);
    chk("blink_on2", digit_valid, 8'h1F);
    btn_mode = 1'b0;
    tick(10);
    chk("held_no_repeat", mode, 1);

    press(0, 1, 0);
    chk("h_inc_wrap", load_h, 4'h0);
    press(0, 1, 0);
    chk("h_inc", load_h, 4'h1);

    press(1, 0, 0);
    chk("setm_mode", mode, 2);
    press(0, 1, 0);
    chk("m_inc59", load_m, 8'h59);
    press(0, 1, 0);
    chk("m_inc_wrap", load_m, 8'h00);

    press(1, 0, 0);
    chk("sets_mode", mode, 3);
    for (int k = 0; k < 21; k++) press(0, 0, 1);
    chk("s_dec_carry", load_s, 8'h09);
    for (int k = 0; k < 10; k++) press(0, 0, 1);
    chk("s_dec_wrap", load_s, 8'h59);

    btn_mode = 1'b1;
    tick(7);
    chk("ld_mode", mode, 0);
    chk("ld_pulse", load, 1);
    chk("ld_tick_en", tick_en, 0);
    chk("ld_h", load_h, 4'h1);
    chk("ld_m", load_m, 8'h00);
    chk("ld_s", load_s, 8'h59);
    tick(1);
    chk("ld_end", load, 0);
    chk("run_tick_en", tick_en, 1);
    chk("ld_hold_h", load_h, 4'h1);
    btn_mode = 1'b0;
    tick(10);

    press(0, 1, 0);
    chk("run_ignore_inc", load_h, 4'h1);

    press(1, 0, 0);
    press(1, 0, 0);
    chk("glitch_setup", mode, 2);
    btn_inc = 1'b1;
    tick(2);
    btn_inc = 1'b0;
    tick(12);
    chk("glitch_m", load_m, 8'h58);
    press(0, 1, 1);
    chk("incdec_m", load_m, 8'h58);

    press(1, 0, 0);
    press(1, 0, 0);
    chk("back_run", mode, 0);
    cur_m = 8'h7A;
    press(1, 0, 0);
    chk("bad_m_cap", load_m, 8'h00);
    press(1, 1, 0);
    chk("modeinc_mode", mode, 2);
    chk("modeinc_h", load_h, 4'h9);

    press(1, 0, 0);
    chk("pre_rst_mode", mode, 3);
    load_seen = 1'b0;
    tick(2);
    rst = 1'b0;
    #1;
    chk("arst_mode", mode, 0);
    chk("arst_tick_en", tick_en, 1);
    chk("arst_load", load, 0);
    chk("arst_dv", digit_valid, 8'h1F);
    tick(2);
    rst = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick(1);
      if (load) load_seen = 1'b1;
    end
    chk("arst_no_load", load_seen, 0);
    chk("arst_run", mode, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

endmodule
